// File: rtl/player_controller_if.sv
// Drawer handshake: controller publishes pixel position and a redraw request.
// The drawer answers with a single-cycle acknowledge when drawing completes.
interface player_controller_if;
  logic [8:0] x;
  logic [8:0] y;
  logic       redraw_req;
  logic       redraw_ack;

  modport master (output x, output y, output redraw_req, input redraw_ack);
  modport slave  (input x, input y, input redraw_req, output redraw_ack);
endinterface

// File: rtl/player_controller.sv
// Maze player controller: debounced buttons move a cell cursor through a 10x15 wall grid.
// Event -> new position/redraw_req in 2 cycles; holds redraw_req until the drawer acks.
module player_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CELL_SIZE       = 16,
  parameter int X_ORIGIN        = 0,
  parameter int Y_ORIGIN        = 0,
  parameter int START_COL       = 0,
  parameter int START_ROW       = 0,
  parameter int GOAL_COL        = 9,
  parameter int GOAL_ROW        = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic [159:0]         h_walls,
  input  logic [164:0]         v_walls,
  output logic [3:0]           col,
  output logic [3:0]           row,
  output logic                 blocked,
  output logic                 won,
  player_controller_if.master  drw
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [8:0] X_START = 9'(X_ORIGIN + START_COL * CELL_SIZE);
  localparam logic [8:0] Y_START = 9'(Y_ORIGIN + START_ROW * CELL_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REDRAW, S_WON} state_t;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  // Bit order everywhere: 0=up, 1=down, 2=left, 3=right
  logic [3:0]    w_btn;
  logic [3:0]    r_sync1, r_sync2, r_prev, r_deb, r_armed, r_evt;
  logic [CW-1:0] r_cnt [4];

  assign w_btn = {btn_right, btn_left, btn_down, btn_up};

  // A button is armed only once a stable release has been accepted, so a
  // button held through reset cannot generate an event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_deb   <= '0;
      r_armed <= '0;
      r_evt   <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      for (int i = 0; i < 4; i++) begin
        r_evt[i] <= 1'b0;
        if (r_sync2[i] != r_prev[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] != CNT_MAX) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else begin
          r_deb[i] <= r_prev[i];
          if (!r_prev[i]) r_armed[i] <= 1'b1;
          if (r_prev[i] && !r_deb[i] && r_armed[i]) r_evt[i] <= 1'b1;
        end
      end
    end
  end

  state_t     r_state;
  dir_t       r_dir;
  logic [3:0] r_col, r_row;
  logic [8:0] r_x, r_y;
  logic       r_req, r_blocked, r_won;

  logic       w_any;
  dir_t       w_dir;
  logic [7:0] w_up_idx, w_dn_idx, w_lt_idx, w_rt_idx;
  logic       w_blk;
  logic [3:0] w_new_col, w_new_row;
  logic [8:0] w_new_x, w_new_y;
  logic       w_at_goal;

  always_comb begin
    w_any = |r_evt;
    w_dir = D_RIGHT;
    if (r_evt[0])      w_dir = D_UP;
    else if (r_evt[1]) w_dir = D_DOWN;
    else if (r_evt[2]) w_dir = D_LEFT;
  end

  assign w_up_idx = 8'(r_row) * 8'd10 + 8'(r_col);
  assign w_dn_idx = (8'(r_row) + 8'd1) * 8'd10 + 8'(r_col);
  assign w_lt_idx = 8'(r_row) * 8'd11 + 8'(r_col);
  assign w_rt_idx = w_lt_idx + 8'd1;

  // Grid edges refuse the move independently of the wall bits.
  always_comb begin
    w_blk     = 1'b0;
    w_new_col = r_col;
    w_new_row = r_row;
    case (r_dir)
      D_UP:    if (r_row == 4'd0  || h_walls[w_up_idx]) w_blk = 1'b1; else w_new_row = r_row - 4'd1;
      D_DOWN:  if (r_row == 4'd14 || h_walls[w_dn_idx]) w_blk = 1'b1; else w_new_row = r_row + 4'd1;
      D_LEFT:  if (r_col == 4'd0  || v_walls[w_lt_idx]) w_blk = 1'b1; else w_new_col = r_col - 4'd1;
      default: if (r_col == 4'd9  || v_walls[w_rt_idx]) w_blk = 1'b1; else w_new_col = r_col + 4'd1;
    endcase
  end

  assign w_new_x   = 9'(X_ORIGIN + int'(w_new_col) * CELL_SIZE);
  assign w_new_y   = 9'(Y_ORIGIN + int'(w_new_row) * CELL_SIZE);
  assign w_at_goal = (r_col == 4'(GOAL_COL)) && (r_row == 4'(GOAL_ROW));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_dir     <= D_UP;
      r_col     <= 4'(START_COL);
      r_row     <= 4'(START_ROW);
      r_x       <= X_START;
      r_y       <= Y_START;
      r_req     <= 1'b0;
      r_blocked <= 1'b0;
      r_won     <= 1'b0;
    end else begin
      r_blocked <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_dir   <= w_dir;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_blk) begin
            r_blocked <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_col   <= w_new_col;
            r_row   <= w_new_row;
            r_x     <= w_new_x;
            r_y     <= w_new_y;
            r_req   <= 1'b1;
            r_state <= S_REDRAW;
          end
        end
        S_REDRAW: begin
          if (drw.redraw_ack) begin
            r_req <= 1'b0;
            if (w_at_goal) begin
              r_won   <= 1'b1;
              r_state <= S_WON;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_WON:   r_won   <= 1'b1;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign col            = r_col;
  assign row            = r_row;
  assign blocked        = r_blocked;
  assign won            = r_won;
  assign drw.x          = r_x;
  assign drw.y          = r_y;
  assign drw.redraw_req = r_req;

endmodule

// File: tb/tb_player_controller.sv
// Randomized bench for player_controller against a cell-level position model.
module tb_player_controller;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [159:0] h_walls = '0;
  logic [164:0] v_walls = '0;
  logic [3:0]   col, row;
  logic         blocked, won;

  player_controller_if dif();

  player_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .h_walls(h_walls), .v_walls(v_walls),
    .col(col), .row(row), .blocked(blocked), .won(won),
    .drw(dif)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Drawer: random-latency acknowledge, or a manually driven one.
  logic ack_drv = 1'b0;
  bit   auto_ack = 1'b1;
  bit   man_ack = 1'b0;
  int   ack_wait = 0;
  assign dif.redraw_ack = ack_drv;

  always @(negedge clk) begin
    if (!auto_ack) ack_drv = man_ack;
    else if (ack_drv) ack_drv = 1'b0;
    else if (dif.redraw_req) begin
      if (ack_wait == 0) begin
        ack_drv  = 1'b1;
        ack_wait = $urandom_range(0, 3);
      end else ack_wait--;
    end
  end

  // Counts blocked cycles and redraw requests (moves).
  int n_blk_tot = 0;
  int n_mov_tot = 0;
  bit req_q = 1'b0;
  always @(negedge clk) begin
    if (blocked === 1'b1) n_blk_tot++;
    if (dif.redraw_req === 1'b1 && !req_q) n_mov_tot++;
    req_q = (dif.redraw_req === 1'b1);
  end

  // Reference model at cell granularity.
  int mc = 0, mr = 0;
  bit mwon = 0;
  int exp_blk, exp_mov;

  task automatic model(input logic [3:0] b);
    int nc, nr;
    bit wall, out;
    exp_blk = 0;
    exp_mov = 0;
    if (b == 4'd0 || mwon) return;
    nc = mc;
    nr = mr;
    if (b[0])      begin out = (mr == 0); wall = h_walls[mr*10+mc];     nr = mr - 1; end
    else if (b[1]) begin out = (mr == 14); wall = h_walls[(mr+1)*10+mc]; nr = mr + 1; end
    else if (b[2]) begin out = (mc == 0); wall = v_walls[mr*11+mc];     nc = mc - 1; end
    else           begin out = (mc == 9); wall = v_walls[mr*11+mc+1];   nc = mc + 1; end
    if (out || wall) exp_blk = 1;
    else begin
      exp_mov = 1;
      mc = nc;
      mr = nr;
      if (mc == 9 && mr == 14) mwon = 1;
    end
  endtask

  task automatic set_btns(input logic [3:0] b);
    {btn_right, btn_left, btn_down, btn_up} = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_x", dif.x, 0);
    chk("rst_y", dif.y, 0);
    chk("rst_req", dif.redraw_req, 0);
    chk("rst_blk", blocked, 0);
    chk("rst_won", won, 0);
    mc = 0;
    mr = 0;
    mwon = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_press(input logic [3:0] b, input int hold);
    int b0, m0;
    model(b);
    b0 = n_blk_tot;
    m0 = n_mov_tot;
    @(negedge clk);
    set_btns(b);
    repeat (hold) @(negedge clk);
    set_btns(4'd0);
    repeat (12) @(negedge clk);
    for (int k = 0; k < 40 && dif.redraw_req; k++) @(negedge clk);
    chk("settle_req", dif.redraw_req, 0);
    chk("n_blocked", n_blk_tot - b0, exp_blk);
    chk("n_moves", n_mov_tot - m0, exp_mov);
    chk("col", col, mc);
    chk("row", row, mr);
    chk("x", dif.x, mc * 16);
    chk("y", dif.y, mr * 16);
    chk("won", won, mwon);
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    #1 man_ack = 1'b1;
    @(posedge clk);
    #1 man_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_walls();
    for (int i = 0; i < 160; i++) h_walls[i] = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 165; i++) v_walls[i] = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int m0, b0;
    logic [3:0] b;

    do_reset();

    // Leaving the grid at the top is refused.
    do_press(4'b0001, 12);

    // Held right: one move, request stays up until acked, presses in REDRAW dropped.
    auto_ack = 1'b0;
    m0 = n_mov_tot;
    model(4'b1000);
    @(negedge clk);
    btn_right = 1'b1;
    repeat (25) @(negedge clk);
    chk("hold_req", dif.redraw_req, 1);
    chk("hold_col", col, 1);
    chk("hold_x", dif.x, 16);
    btn_right = 1'b0;
    repeat (12) @(negedge clk);
    btn_down = 1'b1;
    repeat (15) @(negedge clk);
    btn_down = 1'b0;
    repeat (12) @(negedge clk);
    chk("redraw_row", row, 0);
    chk("redraw_req", dif.redraw_req, 1);
    pulse_ack();
    chk("ack_drop", dif.redraw_req, 0);
    chk("one_move", n_mov_tot - m0, 1);
    auto_ack = 1'b1;

    // Two-cycle glitch is filtered.
    m0 = n_mov_tot;
    b0 = n_blk_tot;
    btn_down = 1'b1;
    repeat (2) @(negedge clk);
    btn_down = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_moves", n_mov_tot - m0, 0);
    chk("glitch_blk", n_blk_tot - b0, 0);
    chk("glitch_row", row, 0);

    // Wall to the right of (0,0).
    do_reset();
    v_walls[1] = 1'b1;
    do_press(4'b1000, 10);
    v_walls[1] = 1'b0;
    do_press(4'b1000, 10);

    // Simultaneous up+left at (3,3): up wins.
    do_reset();
    repeat (3) do_press(4'b1000, 9);
    repeat (3) do_press(4'b0010, 9);
    do_press(4'b0101, 12);

    // Reset mid-REDRAW with the button still held through reset.
    do_reset();
    auto_ack = 1'b0;
    @(negedge clk);
    btn_right = 1'b1;
    repeat (20) @(negedge clk);
    chk("pre_rst_req", dif.redraw_req, 1);
    rst = 1'b0;
    #2;
    chk("abandon_req", dif.redraw_req, 0);
    @(negedge clk);
    rst = 1'b1;
    m0 = n_mov_tot;
    repeat (20) @(negedge clk);
    chk("held_rst_moves", n_mov_tot - m0, 0);
    pulse_ack();
    chk("stale_ack_req", dif.redraw_req, 0);
    chk("stale_ack_col", col, 0);
    btn_right = 1'b0;
    auto_ack = 1'b1;
    repeat (12) @(negedge clk);
    mc = 0;
    mr = 0;
    mwon = 0;
    do_press(4'b1000, 10);

    // Random walls and presses.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if (n % 8 == 0) rand_walls();
      if ($urandom_range(0, 9) < 7) b = 4'b0001 << $urandom_range(0, 3);
      else b = 4'($urandom_range(1, 15));
      do_press(b, $urandom_range(8, 20));
    end

    // Walk to the goal, then the position freezes.
    h_walls = '0;
    v_walls = '0;
    do_reset();
    repeat (9) do_press(4'b1000, 9);
    repeat (14) do_press(4'b0010, 9);
    chk("goal_won", won, 1);
    do_press(4'b0001, 10);
    do_press(4'b0100, 10);
    do_reset();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/player_controller.md
PLAYER_CONTROLLER -- requirements
Module: player_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 250000, number of consecutive stable cycles for a button to be accepted.
REQ-002 Parameter CELL_SIZE, 16, cell pitch in pixels.
REQ-003 Parameter X_ORIGIN, 0, pixel x of cell column 0.
REQ-004 Parameter Y_ORIGIN, 0, pixel y of cell row 0.
REQ-005 Parameters START_COL/START_ROW, 0/0, reset cell.
REQ-006 Parameters GOAL_COL/GOAL_ROW, 9/14, win cell.
REQ-007 clk  in  1  system clock; all state changes on rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 btn_up, btn_down, btn_left, btn_right  in  1 each  raw asynchronous buttons, active-high.
REQ-010 h_walls  in  160  horizontal wall segments, 16 lines x 10 columns, quasi-static.
REQ-011 v_walls  in  165  vertical wall segments, 15 rows x 11 lines, quasi-static.
REQ-012 col  out  4  current cell column, 0..9.
REQ-013 row  out  4  current cell row, 0..14.
REQ-014 x, y  out  9 each  pixel position, feeding the player drawer's x/y.
REQ-015 redraw_req  out  1  request to redraw the player at x/y.
REQ-016 redraw_ack  in  1  single-cycle acknowledge from the drawer on completion.
REQ-017 blocked  out  1  one-cycle pulse when a move is refused.
REQ-018 won  out  1  sticky flag, set on reaching the goal cell.

Function
REQ-019 Wall indexing for cell (c,r): up = h_walls[r*10+c], down = h_walls[(r+1)*10+c], left = v_walls[r*11+c], right = v_walls[r*11+c+1]; bit=1 means wall present.
REQ-020 Each button passes through a 2-flop synchronizer before any other logic.
REQ-021 Debounce per button: counter reset on any change of the synchronized value; the debounced value is updated when the counter reaches DEBOUNCE_CYCLES-1; counter saturates and does not wrap.
REQ-022 A move event is a one-cycle pulse on a 0->1 edge of a debounced button; holding a button produces exactly one event.
REQ-023 Simultaneous events are resolved by priority up > down > left > right; lower-priority events in the same cycle are discarded.
REQ-024 FSM states: IDLE, CHECK, REDRAW, WON.
REQ-025 IDLE: on an event, latch the direction and go to CHECK next cycle; events in every other state are discarded.
REQ-026 CHECK (1 cycle): a move is blocked if the wall bit is 1, or if it would leave the grid (col 0 left, col 9 right, row 0 up, row 14 down) regardless of wall bits.
REQ-027 Blocked: pulse blocked for one cycle, col/row unchanged, return to IDLE.
REQ-028 Free: on the cycle after CHECK, update col/row and x = X_ORIGIN + col*CELL_SIZE, y = Y_ORIGIN + row*CELL_SIZE (same edge), assert redraw_req, enter REDRAW.
REQ-029 Latency: event pulse at cycle N -> col/row/x/y/redraw_req valid at N+2.
REQ-030 REDRAW: redraw_req held high until redraw_ack is sampled high; deasserted on the following edge; then WON if (col,row) = goal, else IDLE.
REQ-031 redraw_ack outside REDRAW is ignored.
REQ-032 WON: won=1, all events discarded, position frozen; exited only by reset.
REQ-033 x/y arithmetic is unsigned 9-bit, truncated; parameters are chosen so that no overflow occurs.

Reset
REQ-034 Asserting rst immediately forces: FSM=IDLE, col=START_COL, row=START_ROW, x/y at the start cell, redraw_req=0, blocked=0, won=0, synchronizers/debounce values=0, counters=0.
REQ-035 Reset during REDRAW abandons the request; a subsequent redraw_ack has no effect.
REQ-036 After rst deassertion, buttons already held produce no event until released and pressed again.

Verification (DEBOUNCE_CYCLES=4)
REQ-037 Empty walls, start (0,0), btn_right pressed and held -> exactly one move; col=1, x=16, redraw_req high until ack.
REQ-038 At (0,0), btn_up -> blocked pulse for one cycle; col/row stay 0; redraw_req stays 0.
REQ-039 v_walls[1]=1 at (0,0), btn_right -> blocked; with v_walls[1]=0 -> col=1.
REQ-040 btn_up and btn_left debounced in the same cycle at (3,3) with no walls -> row=2, col=3.
REQ-041 A 2-cycle glitch on btn_down -> no event; a second press during REDRAW -> discarded.
REQ-042 Walk to (9,14), ack the redraw -> won=1; further presses do not change col/row; rst low -> won=0, back at (0,0).
